mc_muldiv: RTL
==============

Name: mc_muldiv

Overview:
- Iterative multiply/divide unit for the multi-cycle CPU.
- Sits directly downstream of the A and B operand registers. Consumes their latched 32-bit outputs and produces the HI/LO result pair.
- The control FSM pulses start in the EX state and stalls until done.
- Supports MULT, MULTU, DIV and DIVU using a radix-2 shift-add / restoring-subtract datapath, one bit per cycle.

Parameters:
- WIDTH, 32, operand width; hi/lo are WIDTH bits each. Iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, all state updates on posedge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request; sampled only in IDLE
- op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with start
- a_data  input  WIDTH  operand A from the A register: multiplicand or dividend
- b_data  input  WIDTH  operand B from the B register: multiplier or divisor
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse; hi/lo valid in the same cycle
- hi  output  WIDTH  product upper half / remainder
- lo  output  WIDTH  product lower half / quotient

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - state=IDLE
  - busy=0, done=0, hi=0, lo=0
  - iteration counter=0
  - all internal operand and sign registers cleared
- States:
  - IDLE -> CALC on start=1
  - CALC -> FIX when counter reaches WIDTH-1
  - FIX -> DONE unconditionally
  - DONE -> IDLE unconditionally
- Accept (edge where start=1 in IDLE):
  - Latch op, a_data, b_data.
  - For signed ops (op[0]=1): record sa=a[MSB], sb=b[MSB]; store two's-complement magnitudes.
  - For unsigned ops: sa=sb=0.
  - Clear the counter.
- CALC runs exactly WIDTH cycles, one iteration each, counter incrementing 0..WIDTH-1.
  - Multiply: 2*WIDTH-bit accumulator with shift-add on the multiplier LSB.
  - Divide: restoring division. WIDTH+1-bit partial remainder; quotient bit=1 when the trial subtract is non-negative.
- FIX (sign correction):
  - Multiply: negate the 2*WIDTH-bit product if sa^sb.
  - Divide: negate the quotient if sa^sb; negate the remainder if sa (remainder takes the sign of the dividend).
- DONE:
  - hi/lo loaded on the FIX->DONE edge, so they are valid while done=1.
  - done=1 for exactly one cycle.
  - busy=0 in the DONE cycle.
  - hi/lo held unchanged until the next accept's DONE or reset.
- Latency (edge where start is sampled = cycle 0):
  - busy=1 during cycles 1..WIDTH+1.
  - done=1 at cycle WIDTH+2 (34 for WIDTH=32).
- Back-to-back: start asserted in the DONE cycle is ignored. Earliest accept is the next cycle in IDLE.
- start while busy or in DONE: ignored, with no effect on the operation in flight. op/a_data/b_data changes after accept are ignored.
- Divide by zero (b=0, DIV or DIVU):
  - lo=all ones.
  - hi=original a_data, unmodified (no sign processing).
  - Flagged at accept; the FIX stage forces these values.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (natural two's-complement wrap, no trap).
- MULT of the most negative value: magnitude 2^(WIDTH-1) handled as unsigned with no loss. Product exact within 2*WIDTH bits.

Optional Feature:
- Macro: MULDIV_DIVZERO_FAST_EN
- Defined: a divide by zero skips CALC.
  - Transitions IDLE -> FIX -> DONE.
  - busy=1 at cycle 1 only; done at cycle 2.
  - Result values are identical to the non-fast case.
- Undefined: a divide by zero runs the full WIDTH CALC cycles. done at cycle WIDTH+2 with the forced result.
- Multiply and non-zero divide timing are unaffected either way.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> at cycle 34: done=1, hi=0xFFFFFFFE, lo=0x00000001; busy high for cycles 1..33 exactly.
- MULT a=0xFFFFFFFD (-3) b=0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
  - MULT a=0x80000000 b=0x80000000 -> hi=0x40000000, lo=0x00000000.
- DIVU a=100 b=7 -> lo=14, hi=2.
  - DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=5 b=0 -> lo=0xFFFFFFFF, hi=5. done at cycle 34 without MULDIV_DIVZERO_FAST_EN; at cycle 2 with it.
- Start MULTU 3*4, pulse start with op=DIVU a=9 b=3 at cycle 5 -> ignored; result hi=0, lo=12.
  - Then start a new MULTU 6*7 and assert rst_n=0 at cycle 10 -> busy/done/hi/lo=0 immediately, with no clock edge required.
  - After release, start MULTU 2*3 -> lo=6 at cycle 34.
- Start asserted in the DONE cycle -> ignored, no busy the next cycle.
  - Start one cycle later -> accepted.
  - hi/lo hold the previous result until the new done.

Source files
------------

// File: rtl/mc_muldiv_if.sv
// Operand/result bundle between the multi-cycle CPU control and the mc_muldiv unit.
interface mc_muldiv_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a_data;
   logic [WIDTH-1:0] b_data;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, a_data, b_data,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, a_data, b_data,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/mc_muldiv.sv
// Radix-2 iterative MULT/MULTU/DIV/DIVU unit producing the HI/LO pair.
// Optional MULDIV_DIVZERO_FAST_EN: a divide by zero skips the iteration phase.
module mc_muldiv #(
   parameter int unsigned WIDTH = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   mc_muldiv_if.slave  bus
);
   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned P_W   = 2 * WIDTH;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIX,
      S_DONE
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             is_div, is_div_nxt;
   logic             dz, dz_nxt;
   logic             sa, sa_nxt;
   logic             sb, sb_nxt;
   logic [WIDTH-1:0] mag_a, mag_a_nxt;
   logic [WIDTH-1:0] mag_b, mag_b_nxt;
   logic [WIDTH:0]   acc_hi, acc_hi_nxt;
   logic [WIDTH-1:0] acc_lo, acc_lo_nxt;
   logic             busy, busy_nxt;
   logic             done, done_nxt;
   logic [WIDTH-1:0] hi, hi_nxt;
   logic [WIDTH-1:0] lo, lo_nxt;

   logic             a_neg_c, b_neg_c, b_zero_c;
   logic [WIDTH:0]   mul_sum_c;
   logic [WIDTH:0]   div_shift_c;
   logic [WIDTH+1:0] div_trial_c;
   logic [P_W-1:0]   prod_c, prod_neg_c;
   logic [WIDTH-1:0] quo_neg_c, rem_neg_c, a_orig_c;

   // Operand sign capture at accept
   assign a_neg_c  = bus.op[0] & bus.a_data[WIDTH-1];
   assign b_neg_c  = bus.op[0] & bus.b_data[WIDTH-1];
   assign b_zero_c = (bus.b_data == '0);

   // Shift-add step: acc_hi is the running upper half, acc_lo holds remaining multiplier bits
   assign mul_sum_c = acc_hi + (acc_lo[0] ? {1'b0, mag_a} : {(WIDTH+1){1'b0}});

   // Restoring-divide step: acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in
   assign div_shift_c = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
   assign div_trial_c = {1'b0, div_shift_c} - {2'b00, mag_b};

   assign prod_c     = {acc_hi[WIDTH-1:0], acc_lo};
   assign prod_neg_c = P_W'(0) - prod_c;
   assign quo_neg_c  = WIDTH'(0) - acc_lo;
   assign rem_neg_c  = WIDTH'(0) - acc_hi[WIDTH-1:0];
   // Divide by zero returns the dividend untouched; undo the magnitude conversion
   assign a_orig_c   = sa ? (WIDTH'(0) - mag_a) : mag_a;

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      is_div_nxt = is_div;
      dz_nxt     = dz;
      sa_nxt     = sa;
      sb_nxt     = sb;
      mag_a_nxt  = mag_a;
      mag_b_nxt  = mag_b;
      acc_hi_nxt = acc_hi;
      acc_lo_nxt = acc_lo;
      hi_nxt     = hi;
      lo_nxt     = lo;

      case (state)
         S_IDLE: begin
            if (bus.start) begin
               is_div_nxt = bus.op[1];
               dz_nxt     = bus.op[1] & b_zero_c;
               sa_nxt     = a_neg_c;
               sb_nxt     = b_neg_c;
               mag_a_nxt  = a_neg_c ? (WIDTH'(0) - bus.a_data) : bus.a_data;
               mag_b_nxt  = b_neg_c ? (WIDTH'(0) - bus.b_data) : bus.b_data;
               acc_hi_nxt = '0;
               acc_lo_nxt = bus.op[1] ? mag_a_nxt : mag_b_nxt;
               cnt_nxt    = '0;
`ifdef MULDIV_DIVZERO_FAST_EN
               state_nxt  = (bus.op[1] && b_zero_c) ? S_FIX : S_CALC;
`else
               state_nxt  = S_CALC;
`endif
            end
         end
         S_CALC: begin
            if (is_div) begin
               acc_hi_nxt = div_trial_c[WIDTH+1] ? div_shift_c : div_trial_c[WIDTH:0];
               acc_lo_nxt = {acc_lo[WIDTH-2:0], ~div_trial_c[WIDTH+1]};
            end else begin
               acc_hi_nxt = {1'b0, mul_sum_c[WIDTH:1]};
               acc_lo_nxt = {mul_sum_c[0], acc_lo[WIDTH-1:1]};
            end
            cnt_nxt = cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 1)) begin
               cnt_nxt   = '0;
               state_nxt = S_FIX;
            end
         end
         S_FIX: begin
            if (is_div) begin
               if (dz) begin
                  hi_nxt = a_orig_c;
                  lo_nxt = '1;
               end else begin
                  hi_nxt = sa ? rem_neg_c : acc_hi[WIDTH-1:0];
                  lo_nxt = (sa ^ sb) ? quo_neg_c : acc_lo;
               end
            end else begin
               {hi_nxt, lo_nxt} = (sa ^ sb) ? prod_neg_c : prod_c;
            end
            state_nxt = S_DONE;
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase

      busy_nxt = (state_nxt == S_CALC) || (state_nxt == S_FIX);
      done_nxt = (state_nxt == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         cnt    <= '0;
         is_div <= 1'b0;
         dz     <= 1'b0;
         sa     <= 1'b0;
         sb     <= 1'b0;
         mag_a  <= '0;
         mag_b  <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         is_div <= is_div_nxt;
         dz     <= dz_nxt;
         sa     <= sa_nxt;
         sb     <= sb_nxt;
         mag_a  <= mag_a_nxt;
         mag_b  <= mag_b_nxt;
         acc_hi <= acc_hi_nxt;
         acc_lo <= acc_lo_nxt;
         busy   <= busy_nxt;
         done   <= done_nxt;
         hi     <= hi_nxt;
         lo     <= lo_nxt;
      end
   end

   assign bus.busy = busy;
   assign bus.done = done;
   assign bus.hi   = hi;
   assign bus.lo   = lo;
endmodule
